// File: rtl/seq_serializer.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word over valid/ready and
// emits it MSB first with a valid strobe, an end-of-word pulse and optional idle gap.
module seq_serializer #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;
  localparam bit HAS_GAP = (GAP > 0);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = HAS_GAP ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;
  logic             sout_reg, sout_next;
  logic             sout_valid_reg, sout_valid_next;
  logic             done_reg, done_next;
  logic             accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      shreg_reg      <= '0;
      bit_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      sout_reg       <= 1'b0;
      sout_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      bit_cnt_reg    <= bit_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      sout_reg       <= sout_next;
      sout_valid_reg <= sout_valid_next;
      done_reg       <= done_next;
    end
  end

  // Ready depends only on registered state, never on din_valid.
  assign din_ready = (state_reg == S_IDLE)
                  || (state_reg == S_SHIFT && !HAS_GAP && bit_cnt_reg == '0)
                  || (state_reg == S_GAP && gap_cnt_reg == '0);
  assign accept = din_valid && din_ready;

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next   = S_SHIFT;
          shreg_next   = din;
          bit_cnt_next = BIT_LAST;
        end
      end
      S_SHIFT: begin
        shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
        if (bit_cnt_reg != '0) begin
          bit_cnt_next = bit_cnt_reg - 1'b1;
        end else if (HAS_GAP) begin
          state_next   = S_GAP;
          gap_cnt_next = GAP_LOAD;
        end else if (accept) begin
          // Reload on the last bit so consecutive words stream without a bubble.
          shreg_next   = din;
          bit_cnt_next = BIT_LAST;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg != '0) begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end else if (accept) begin
          state_next   = S_SHIFT;
          shreg_next   = din;
          bit_cnt_next = BIT_LAST;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered.
  always_comb begin
    sout_valid_next = (state_next == S_SHIFT);
    sout_next       = sout_valid_next && shreg_next[WIDTH-1];
    done_next       = sout_valid_next && (bit_cnt_next == '0);
  end

  assign sout       = sout_reg;
  assign sout_valid = sout_valid_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: table-driven cycle vectors for GAP=0 and GAP=2,
// then randomized words checked against a queue-based reference model.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din0 = '0, din2 = '0;
  logic       v0 = 1'b0, v2 = 1'b0;
  logic       rdy0, so0, sv0, dn0;
  logic       rdy2, so2, sv2, dn2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(4), .GAP(0)) u0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .din_ready(rdy0),
    .sout(so0), .sout_valid(sv0), .done(dn0)
  );

  seq_serializer #(.WIDTH(4), .GAP(2)) u2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(v2), .din_ready(rdy2),
    .sout(so2), .sout_valid(sv2), .done(dn2)
  );

  // One row per clock cycle; exp = {din_ready, sout, sout_valid, done}.
  typedef struct packed {
    logic       rst;
    logic       v;
    logic [3:0] din;
    logic [3:0] exp;
  } vec_t;

  vec_t tab0[34];
  vec_t tab2[14];

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d,
                              input logic [3:0] e);
    return {r, v, d, e};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic run_row(input int which, input int idx, input vec_t t);
    logic [3:0] obs;
    @(posedge clk); #1;
    rst = t.rst;
    if (which == 0) begin din0 = t.din; v0 = t.v; end
    else begin din2 = t.din; v2 = t.v; end
    @(negedge clk);
    obs = (which == 0) ? {rdy0, so0, sv0, dn0} : {rdy2, so2, sv2, dn2};
    $display("[TB] gap%0d row %0d rst=%b v=%b din=%b -> rdy/so/sv/done=%b", which, idx,
             t.rst, t.v, t.din, obs);
    check($sformatf("tab_gap%0d[%0d]", which, idx), {28'd0, obs}, {28'd0, t.exp});
  endtask

  // Reference model: queue of accepted words, current bit position, and the
  // number of cycles since the last bit of a word left the block.
  task automatic rand_phase(input int which, input int gap);
    logic [3:0] exp_q[$];
    int         bit_idx, since_last, sent, cyc;
    bit         holding;
    logic [3:0] w, asm_w, front;
    logic       e_rdy, e_so, e_sv, e_dn;
    logic       o_rdy, o_so, o_sv, o_dn;
    @(posedge clk); #1;
    rst = 1'b0; v0 = 1'b0; v2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bit_idx = 0; since_last = 100; sent = 0; cyc = 0; holding = 1'b0;
    w = '0; asm_w = '0;
    while ((sent < 50 || exp_q.size() > 0) && cyc < 3000) begin
      cyc++;
      @(posedge clk); #1;
      if (!holding && sent < 50 && $urandom_range(0, 2) != 0) begin
        holding = 1'b1;
        w = 4'($urandom);
      end else if (!holding) begin
        w = 4'($urandom);
      end
      if (which == 0) begin din0 = w; v0 = holding; end
      else begin din2 = w; v2 = holding; end
      @(negedge clk);
      e_sv  = (exp_q.size() > 0);
      front = e_sv ? exp_q[0] : 4'd0;
      e_so  = e_sv ? front[3 - bit_idx] : 1'b0;
      e_dn  = e_sv && (bit_idx == 3);
      e_rdy = (exp_q.size() == 0 && since_last >= gap) || (gap == 0 && e_dn);
      if (which == 0) begin o_rdy = rdy0; o_so = so0; o_sv = sv0; o_dn = dn0; end
      else begin o_rdy = rdy2; o_so = so2; o_sv = sv2; o_dn = dn2; end
      check($sformatf("rand_gap%0d_cyc%0d", which, cyc), {28'd0, o_rdy, o_so, o_sv, o_dn},
            {28'd0, e_rdy, e_so, e_sv, e_dn});
      if (o_sv) asm_w = {asm_w[2:0], o_so};
      if (e_dn) begin
        $display("[TB] gap%0d word out %b (expected %b)", which, asm_w, front);
        check($sformatf("rand_word_gap%0d", which), {28'd0, asm_w}, {28'd0, front});
      end
      if (e_sv) begin
        if (bit_idx == 3) begin
          void'(exp_q.pop_front());
          bit_idx = 0;
          since_last = 0;
        end else begin
          bit_idx++;
        end
      end
      if (since_last < 100) since_last++;
      if (holding && e_rdy) begin
        exp_q.push_back(w);
        sent++;
        holding = 1'b0;
      end
    end
    if (cyc >= 3000) check($sformatf("rand_timeout_gap%0d", which), 32'd1, 32'd0);
    v0 = 1'b0; v2 = 1'b0;
  endtask

  initial begin
    // GAP=0: single word, back-to-back pair, stall with din churn, reset mid-word.
    tab0[0]  = mk(1, 1, 4'b1011, 4'b1000);
    tab0[1]  = mk(1, 0, 4'b1011, 4'b0110);
    tab0[2]  = mk(1, 0, 4'b1011, 4'b0010);
    tab0[3]  = mk(1, 0, 4'b1011, 4'b0110);
    tab0[4]  = mk(1, 0, 4'b1011, 4'b1111);
    tab0[5]  = mk(1, 1, 4'b1011, 4'b1000);
    tab0[6]  = mk(1, 1, 4'b1011, 4'b0110);
    tab0[7]  = mk(1, 1, 4'b1011, 4'b0010);
    tab0[8]  = mk(1, 1, 4'b1011, 4'b0110);
    tab0[9]  = mk(1, 1, 4'b1011, 4'b1111);
    tab0[10] = mk(1, 0, 4'b1011, 4'b0110);
    tab0[11] = mk(1, 0, 4'b1011, 4'b0010);
    tab0[12] = mk(1, 0, 4'b1011, 4'b0110);
    tab0[13] = mk(1, 0, 4'b1011, 4'b1111);
    tab0[14] = mk(1, 0, 4'b1111, 4'b1000);
    tab0[15] = mk(1, 0, 4'b0000, 4'b1000);
    tab0[16] = mk(1, 0, 4'b1111, 4'b1000);
    tab0[17] = mk(1, 1, 4'b0110, 4'b1000);
    tab0[18] = mk(1, 0, 4'b0110, 4'b0010);
    tab0[19] = mk(1, 0, 4'b0110, 4'b0110);
    tab0[20] = mk(1, 0, 4'b0110, 4'b0110);
    tab0[21] = mk(1, 0, 4'b0110, 4'b1011);
    tab0[22] = mk(1, 0, 4'b0110, 4'b1000);
    tab0[23] = mk(1, 1, 4'b1011, 4'b1000);
    tab0[24] = mk(1, 0, 4'b1011, 4'b0110);
    tab0[25] = mk(1, 0, 4'b1011, 4'b0010);
    tab0[26] = mk(0, 0, 4'b1011, 4'b1000);
    tab0[27] = mk(0, 1, 4'b0101, 4'b1000);
    tab0[28] = mk(1, 1, 4'b0101, 4'b1000);
    tab0[29] = mk(1, 0, 4'b0101, 4'b0010);
    tab0[30] = mk(1, 0, 4'b0101, 4'b0110);
    tab0[31] = mk(1, 0, 4'b0101, 4'b0010);
    tab0[32] = mk(1, 0, 4'b0101, 4'b1111);
    tab0[33] = mk(1, 0, 4'b0101, 4'b1000);
    // GAP=2: 1011 then 0110 with the source always valid, then a late source.
    tab2[0]  = mk(1, 1, 4'b1011, 4'b1000);
    tab2[1]  = mk(1, 1, 4'b0110, 4'b0110);
    tab2[2]  = mk(1, 1, 4'b0110, 4'b0010);
    tab2[3]  = mk(1, 1, 4'b0110, 4'b0110);
    tab2[4]  = mk(1, 1, 4'b0110, 4'b0111);
    tab2[5]  = mk(1, 1, 4'b0110, 4'b0000);
    tab2[6]  = mk(1, 1, 4'b0110, 4'b1000);
    tab2[7]  = mk(1, 0, 4'b0110, 4'b0010);
    tab2[8]  = mk(1, 0, 4'b0110, 4'b0110);
    tab2[9]  = mk(1, 0, 4'b0110, 4'b0110);
    tab2[10] = mk(1, 0, 4'b0110, 4'b0011);
    tab2[11] = mk(1, 0, 4'b0110, 4'b0000);
    tab2[12] = mk(1, 0, 4'b0110, 4'b1000);
    tab2[13] = mk(1, 0, 4'b0110, 4'b1000);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_gap0", {28'd0, rdy0, so0, sv0, dn0}, 32'b1000);
    check("reset_gap2", {28'd0, rdy2, so2, sv2, dn2}, 32'b1000);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 34; i++) run_row(0, i, tab0[i]);
    for (int i = 0; i < 14; i++) run_row(2, i, tab2[i]);

    rand_phase(0, 0);
    rand_phase(2, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial transmitter for the FSM sequence-detector path: accepts a WIDTH-bit pattern word over a valid/ready handshake and emits it bit-serially, MSB first, one bit per clock, with a qualifying valid strobe. It is the driving end for the serial sequence detectors, for example streaming 4'b1011 patterns back-to-back. An optional idle gap of GAP cycles can be inserted between words. A per-word done pulse is provided.

## Interface
- WIDTH, 4: bits per word; legal range ≥ 2.
- GAP, 0: idle cycles forced between consecutive words; legal range ≥ 0.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- din  input  WIDTH  word to transmit; sampled only on an accepted handshake.
- din_valid  input  1  source has a word on din.
- din_ready  output  1  block can accept a word this cycle; combinational from state/counters.
- sout  output  1  serial data bit, registered; 0 whenever sout_valid=0.
- sout_valid  output  1  sout carries a payload bit, registered.
- done  output  1  registered; high during the cycle the last bit of a word is on sout.

## Operation
- States: IDLE, SHIFT, GAP.
- Handshake: a word is accepted at a rising edge where din_valid=1 and din_ready=1.
- A word offered while din_ready=0 is not captured. The source holds din and din_valid until it is accepted.
- din changes while the block is not ready are ignored.
- IDLE behaviour:
  - din_ready=1, sout=0, sout_valid=0.
  - On accept: shreg←din; bit_cnt←WIDTH-1; go to SHIFT.
- SHIFT behaviour:
  - sout=shreg[WIDTH-1] and sout_valid=1.
  - Each cycle: shreg shifts left by 1 with 0 fill, and bit_cnt decrements.
  - done=1 when bit_cnt==0.
- SHIFT exit when bit_cnt==0 and GAP==0:
  - din_ready=1.
  - If a word is accepted, reload shreg/bit_cnt and stay in SHIFT. This gives a back-to-back stream with no bubble.
  - Otherwise go to IDLE.
- SHIFT exit when bit_cnt==0 and GAP>0: go to GAP with gap_cnt←GAP-1. din_ready=0.
- GAP behaviour:
  - sout=0, sout_valid=0, done=0.
  - gap_cnt decrements each cycle.
  - din_ready=1 only when gap_cnt==0. An accept then goes straight to SHIFT; otherwise go to IDLE.
- Counter widths:
  - bit_cnt is $clog2(WIDTH) bits.
  - gap_cnt is max(1, $clog2(GAP+1)) bits.
  - No wrap: each counter is only loaded, decremented to 0, then reloaded.
- Reset (rst=0) takes effect immediately, including mid-word:
  - state=IDLE, shreg=0, counters=0, sout=0, sout_valid=0, done=0.
  - The partial word is discarded and is not resumed.
  - din_ready reads 1 (IDLE), but no accept can occur while rst=0.

## Timing
- Latency: accept at edge t, so the first bit (MSB) is on sout/sout_valid from edge t+1. Bit k (MSB=0) is valid in cycle t+1+k.
- A word occupies exactly WIDTH consecutive sout_valid cycles. done coincides with bit WIDTH-1 (the LSB).
- Throughput with GAP=0 and din_valid held high: 1 bit/cycle sustained, with no sout_valid drop between words.
- Inter-word spacing with GAP>0 and the source always valid: exactly GAP cycles of sout_valid=0.
- Spacing when the source is late: spacing is GAP plus the cycles spent in IDLE.
- Reset release: the first accept is possible at the first rising edge after rst goes high.

## Test plan
- WIDTH=4, GAP=0; send din=4'b1011 once.
  - sout=1,0,1,1 on 4 consecutive sout_valid cycles starting 1 cycle after accept.
  - done only on the 4th cycle.
  - Then sout_valid=0 and din_ready=1.
- GAP=0; din_valid held high with 1011 then 1011.
  - 8 contiguous sout_valid cycles carrying 10111011.
  - done on cycles 4 and 8.
  - din_ready high on cycle 4.
- GAP=2; send 1011 then 0110.
  - Output 1011, then exactly 2 cycles of sout_valid=0 with sout=0, then 0110.
  - din_ready low during the first gap cycle, high during the second.
- Back-pressure/stall: din_valid=0 for 3 cycles after the first word.
  - Block sits in IDLE with sout_valid=0.
  - A din change while din_valid=0 has no effect.
  - The next word starts 1 cycle after its accept.
- Reset mid-word: assert rst=0 after 2 bits of 1011 are sent.
  - sout, sout_valid and done go to 0 immediately.
  - After release, a new word 0101 streams cleanly as 0,1,0,1, with no leftover bits.
- Random: 50 random words with random din_valid.
  - A scoreboard reconstructs words from sout/sout_valid in MSB-first order.
  - Every accepted din must match exactly, in order.
